// File: rtl/mm_inst_dispatch.sv
// mm_inst_dispatch: buffers MM instructions from the decoder, validates them and
// drives the matrix-multiply engine's ctrl_instruction / ap_start / ap_done handshake.
// The instruction word is held stable from load until the next legal load, because
// the engine steers its buffer ports combinationally from it.
// Optional: define MM_INST_DISPATCH_PERF_EN to add busy_cycles / stall_cycles counters.
module mm_inst_dispatch #(
  parameter int unsigned INST_W  = 128,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              kernel_clk,
  input  logic              kernel_rst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [INST_W-1:0] inst_data,
  output logic [INST_W-1:0] mm_ctrl_instruction,
  output logic              mm_ap_start,
  input  logic              mm_ap_done,
  output logic              idle,
  output logic              err_illegal,
  output logic              err_timeout,
  input  logic              err_clr,
  output logic [15:0]       issued_cnt
`ifdef MM_INST_DISPATCH_PERF_EN
  ,
  output logic [31:0]       busy_cycles,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Watchdog counter only needs to reach TIMEOUT-1.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  state_e            state_q, state_d;
  logic [INST_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [INST_W-1:0] ctrl_q;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       issued_q;
  logic              err_ill_q, err_tmo_q, idle_q;

  logic              push, pop, empty, load, set_ill, set_tmo, done_ok;
  logic [INST_W-1:0] head;
  logic              head_legal;

  // Ready comes from the registered count only, so a pop never opens it combinationally.
  assign inst_ready = (count_q != CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = inst_valid & inst_ready;
  assign head       = mem_q[rd_ptr_q];

  // One input buffer, one output buffer, and a nonzero node count.
  assign head_legal = $onehot(head[4:1]) && $onehot(head[10:9]) && (head[127:112] != '0);

  // Instruction storage; contents need no reset since pointers define validity.
  always_ff @(posedge kernel_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= inst_data;
    end
  end

  // Next-state and control decode for the dispatch FSM.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    load    = 1'b0;
    set_ill = 1'b0;
    set_tmo = 1'b0;
    done_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) begin
            load    = 1'b1;
            state_d = StStart;
          end else begin
            set_ill = 1'b1;
          end
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Done has priority over a coincident watchdog expiry.
        if (mm_ap_done) begin
          done_ok = 1'b1;
          state_d = StIdle;
        end else if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1))) begin
          set_tmo = 1'b1;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, FIFO bookkeeping, instruction register, counters and sticky flags.
  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ctrl_q    <= '0;
      timer_q   <= '0;
      issued_q  <= '0;
      err_ill_q <= 1'b0;
      err_tmo_q <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (load)    ctrl_q   <= head;
      if (done_ok) issued_q <= issued_q + 16'd1;
      // A new error beats a simultaneous clear.
      if (set_ill) begin
        err_ill_q <= 1'b1;
      end else if (err_clr) begin
        err_ill_q <= 1'b0;
      end
      if (set_tmo) begin
        err_tmo_q <= 1'b1;
      end else if (err_clr) begin
        err_tmo_q <= 1'b0;
      end
      idle_q <= (state_q == StIdle) && empty;
    end
  end

  assign mm_ctrl_instruction = ctrl_q;
  assign mm_ap_start         = (state_q == StStart);
  assign idle                = idle_q;
  assign err_illegal         = err_ill_q;
  assign err_timeout         = err_tmo_q;
  assign issued_cnt          = issued_q;

`ifdef MM_INST_DISPATCH_PERF_EN
  logic [31:0] busy_q, stall_q;

  // Saturating activity counters, cleared only by reset.
  always_ff @(posedge kernel_clk) begin
    if (kernel_rst) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      if ((state_q != StIdle) && (busy_q != '1))           busy_q  <= busy_q + 32'd1;
      if (inst_valid && !inst_ready && (stall_q != '1))    stall_q <= stall_q + 32'd1;
    end
  end

  assign busy_cycles  = busy_q;
  assign stall_cycles = stall_q;
`endif

endmodule
